mac_dot_sequencer: RTL and testbench

Upstream control stage for mac_unit. It accepts a dot-product command and a valid/ready stream of operand pairs. For each pair it issues one MAC operation, with the running accumulator fed back as the MAC c operand. It returns the final 32-bit accumulation plus sticky overflow and underflow flags through a valid/ready result port. It sits between the DSP instruction issue logic and mac_unit; the DSP cluster top instantiates both and wires them together.

---
 rtl/dsp_mac_pkg.sv | 17 +
 rtl/mac_dot_sequencer.sv | 140 ++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared types and constants for the DSP MAC cluster
package dsp_mac_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] MAC_MODE_SIGNED   = 2'b00;
  localparam logic [1:0] MAC_MODE_UNSIGNED = 2'b01;
  localparam logic [1:0] MAC_MODE_MIXED    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

endpackage

// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - dot-product command sequencer feeding mac_unit
// Issues one MAC per operand pair, feeding the running accumulator back as the addend.
module mac_dot_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int MAC_LATENCY = 1,
  parameter int LEN_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] acc_init,
  input  logic [1:0]        mode_in,
  input  logic              saturate_in,
  input  logic              round_in,
  input  logic              abort,
  output logic              busy,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              mac_enable,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic [DATA_W-1:0] mac_c,
  output logic [1:0]        mac_mode,
  output logic              mac_saturate,
  output logic              mac_round,
  input  logic [DATA_W-1:0] mac_result,
  input  logic              mac_overflow,
  input  logic              mac_underflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] dot_result,
  output logic              sticky_ovf,
  output logic              sticky_unf
);

  localparam logic [2:0] WAIT_LOAD = 3'(MAC_LATENCY);

  seq_state_t        state;
  logic [LEN_W-1:0]  count;
  logic [2:0]        wait_cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] dot_q;
  logic [1:0]        mode_q;
  logic              sat_q;
  logic              rnd_q;
  logic              ovf_q;
  logic              unf_q;
  logic              op_fire;

  // abort wins over an operand handshake in the same cycle
  assign op_ready     = (state == ST_ISSUE) && !abort;
  assign op_fire      = op_ready && op_valid;
  assign mac_enable   = op_fire;
  assign mac_a        = op_fire ? op_a : '0;
  assign mac_b        = op_fire ? op_b : '0;
  assign mac_c        = acc;
  assign mac_mode     = mode_q;
  assign mac_saturate = sat_q;
  assign mac_round    = rnd_q;
  assign busy         = (state != ST_IDLE);
  assign res_valid    = (state == ST_DONE);
  assign dot_result   = dot_q;
  assign sticky_ovf   = ovf_q;
  assign sticky_unf   = unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      wait_cnt <= '0;
      acc      <= '0;
      dot_q    <= '0;
      mode_q   <= MAC_MODE_SIGNED;
      sat_q    <= 1'b0;
      rnd_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            if (len != '0) begin
              count  <= len;
              acc    <= acc_init;
              // reserved mode code runs as signed
              mode_q <= (mode_in == MAC_MODE_UNSIGNED || mode_in == MAC_MODE_MIXED) ?
                        mode_in : MAC_MODE_SIGNED;
              sat_q  <= saturate_in;
              rnd_q  <= round_in;
              state  <= ST_ISSUE;
            end else begin
              dot_q <= acc_init;
              state <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (op_fire) begin
            wait_cnt <= WAIT_LOAD;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) begin
              acc   <= mac_result;
              ovf_q <= ovf_q | mac_overflow;
              unf_q <= unf_q | mac_underflow;
              count <= count - LEN_W'(1);
              if (count == LEN_W'(1)) begin
                dot_q <= mac_result;
                state <= ST_DONE;
              end else begin
                state <= ST_ISSUE;
              end
            end
          end
        end
        ST_DONE: begin
          if (abort || res_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb/tb_mac_dot_sequencer.sv - randomized scoreboard bench for mac_dot_sequencer
module tb_mac_dot_sequencer;
  import dsp_mac_pkg::*;

  localparam int LAT = 1;
  localparam int LW  = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic [31:0]   acc_init;
  logic [1:0]    mode_in;
  logic          saturate_in;
  logic          round_in;
  logic          abort;
  logic          busy;
  logic          op_valid;
  logic          op_ready;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic          mac_enable;
  logic [31:0]   mac_a;
  logic [31:0]   mac_b;
  logic [31:0]   mac_c;
  logic [1:0]    mac_mode;
  logic          mac_saturate;
  logic          mac_round;
  logic [31:0]   mac_result;
  logic          mac_overflow;
  logic          mac_underflow;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   dot_result;
  logic          sticky_ovf;
  logic          sticky_unf;

  mac_dot_sequencer #(.MAC_LATENCY(LAT), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .acc_init(acc_init),
    .mode_in(mode_in), .saturate_in(saturate_in), .round_in(round_in), .abort(abort),
    .busy(busy), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_enable(mac_enable), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_mode(mac_mode), .mac_saturate(mac_saturate), .mac_round(mac_round),
    .mac_result(mac_result), .mac_overflow(mac_overflow), .mac_underflow(mac_underflow),
    .res_valid(res_valid), .res_ready(res_ready), .dot_result(dot_result),
    .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [1:0]  m;
    logic        s;
    logic        r;
  } iss_t;

  iss_t        iss_q[$];
  logic [33:0] sb_q[$];
  logic [31:0] pa[$];
  logic [31:0] pb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mac_cnt = 0;
  int rdy_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference MAC: exact a*b+c, range-checked against the mode's 32-bit range.
  function automatic logic [33:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [1:0] m,
                                         input logic s);
    logic signed [67:0] av, bv, cv, full, lo, hi;
    logic ovf, unf;
    logic [31:0] r;
    if (m == 2'b01) begin
      av = {36'd0, a};
      bv = {36'd0, b};
      cv = {36'd0, c};
      lo = 68'sd0;
      hi = 68'sd4294967295;
    end else begin
      av = {{36{a[31]}}, a};
      bv = (m == 2'b10) ? {36'd0, b} : {{36{b[31]}}, b};
      cv = {{36{c[31]}}, c};
      lo = -68'sd2147483648;
      hi = 68'sd2147483647;
    end
    full = av * bv + cv;
    ovf  = (full > hi);
    unf  = (full < lo);
    r    = full[31:0];
    if (s && ovf) r = hi[31:0];
    if (s && unf) r = lo[31:0];
    return {unf, ovf, r};
  endfunction

  logic [33:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mac_fn(mac_a, mac_b, mac_c, mac_mode, mac_saturate);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mac_result    = pipe[LAT-1][31:0];
  assign mac_overflow  = pipe[LAT-1][32];
  assign mac_underflow = pipe[LAT-1][33];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_op();
    if ($urandom_range(0, 1) == 1) return $urandom;
    return 32'($urandom_range(0, 40)) - 32'd20;
  endfunction

  // Monitor: checks every MAC issue and every presented result against the queues.
  initial begin
    forever begin
      iss_t e;
      logic [33:0] f;
      @(negedge clk);
      if (op_ready) rdy_cnt++;
      if (mac_enable) begin
        mac_cnt++;
        if (iss_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mac_issue: got unexpected mac_enable expected none");
        end else begin
          e = iss_q.pop_front();
          chk("mac_a", 64'(mac_a), 64'(e.a));
          chk("mac_b", 64'(mac_b), 64'(e.b));
          chk("mac_c", 64'(mac_c), 64'(e.c));
          chk("mac_cfg", 64'({mac_mode, mac_saturate, mac_round}), 64'({e.m, e.s, e.r}));
        end
      end
      if (res_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_valid: got unexpected result %0h expected none", dot_result);
        end else begin
          f = sb_q[0];
          chk("dot_result", 64'(dot_result), 64'(f[31:0]));
          chk("sticky", 64'({sticky_unf, sticky_ovf}), 64'(f[33:32]));
          if (res_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic run_cmd(input int n, input logic [31:0] init, input logic [1:0] m,
                         input logic s, input logic r, input int gap_at, input int gap_len,
                         input int rr_delay, input int abort_after, input bit start_in_done,
                         input bit use_kv, input logic [33:0] kv);
    logic [31:0] acc;
    logic ovf, unf;
    logic [33:0] mr;
    logic [1:0] em;
    iss_t e;
    int hs_cyc, mac0, rdy0, k;
    bit got;
    acc = init; ovf = 1'b0; unf = 1'b0; hs_cyc = 0;
    em = (m == 2'b11) ? MAC_MODE_SIGNED : m;
    res_ready = (rr_delay == 0);
    @(posedge clk); #1;
    start = 1'b1; len = LW'(n); acc_init = init; mode_in = m; saturate_in = s; round_in = r;
    mac0 = mac_cnt; rdy0 = rdy_cnt;
    @(posedge clk); #1;
    start = 1'b0; len = LW'($urandom); acc_init = $urandom; mode_in = 2'($urandom);
    saturate_in = 1'($urandom); round_in = 1'($urandom);
    if (n == 0) chk("zero_len_res_valid", 64'(res_valid), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) break;
      if (i == gap_at) repeat (gap_len) begin @(posedge clk); #1; end
      e.a = pa[i]; e.b = pb[i]; e.c = acc; e.m = em; e.s = s; e.r = r;
      iss_q.push_back(e);
      mr = mac_fn(pa[i], pb[i], acc, m, s);
      acc = mr[31:0]; ovf = ovf | mr[32]; unf = unf | mr[33];
      op_a = pa[i]; op_b = pb[i]; op_valid = 1'b1; k = 0;
      do begin
        @(negedge clk);
        got = op_ready;
        if (got && i == 0) hs_cyc = cyc;
        @(posedge clk); #1;
        k++;
      end while (!got && k < 20);
      op_valid = 1'b0; op_a = $urandom; op_b = $urandom;
      if (!got) begin
        checks++; errors++;
        $display("FAIL op_handshake: got no op_ready expected within 20 cycles");
        return;
      end
    end
    if (abort_after >= 0) begin
      abort = 1'b1; op_valid = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; op_valid = 1'b0;
      chk("abort_idle", 64'(busy), 64'd0);
      chk("abort_issues", 64'(mac_cnt - mac0), 64'(abort_after));
      return;
    end
    sb_q.push_back(use_kv ? kv : {unf, ovf, acc});
    k = 0;
    do begin @(negedge clk); got = res_valid; k++; end while (!got && k < 60);
    if (!got) begin
      checks++; errors++;
      $display("FAIL res_wait: got no res_valid expected within 60 cycles");
      sb_q.delete();
      return;
    end
    if (n > 0 && (gap_len == 0 || gap_at >= n))
      chk("latency", 64'(cyc - hs_cyc), 64'(n * (LAT + 1)));
    if (rr_delay > 0) begin
      for (int j = 0; j < rr_delay - 1; j++) begin
        @(posedge clk); #1;
        start = (j == 0) && start_in_done;
        len = LW'(1);
      end
      @(posedge clk); #1;
      start = 1'b0; res_ready = 1'b1;
      k = 0;
      do begin @(negedge clk); got = res_valid && res_ready; k++; end while (!got && k < 10);
      if (!got) begin
        checks++; errors++;
        $display("FAIL res_handshake: got no handshake expected one");
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_after_result", 64'(busy), 64'd0);
    chk("mac_issue_count", 64'(mac_cnt - mac0), 64'(n));
    if (n == 0) chk("zero_len_no_ready", 64'(rdy_cnt - rdy0), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ga, gl, rr, ab;
    bit sid;
    rst_n = 1'b0; start = 1'b0; len = '0; acc_init = '0; mode_in = '0; saturate_in = 1'b0;
    round_in = 1'b0; abort = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_ready", 64'(op_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_mac_enable", 64'(mac_enable), 64'd0);
    chk("rst_dot_result", 64'(dot_result), 64'd0);
    chk("rst_sticky", 64'({sticky_ovf, sticky_unf}), 64'd0);
    chk("rst_mac_c", 64'(mac_c), 64'd0);
    chk("rst_mac_cfg", 64'({mac_mode, mac_saturate, mac_round}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    pa.delete(); pb.delete();
    pa.push_back(32'd2); pb.push_back(32'd3);
    pa.push_back(32'd4); pb.push_back(32'd5);
    pa.push_back(32'hFFFFFFFF); pb.push_back(32'd6);
    run_cmd(3, 32'd0, 2'b00, 1'b0, 1'b0, -1, 0, 0, -1, 1'b0, 1'b1, {2'b00, 32'h00000014});

    run_cmd(0, 32'h00001234, 2'b00, 1'b0, 1'b0, -1, 0, 0, -1, 1'b0, 1'b1, {2'b00, 32'h00001234});

    pa.delete(); pb.delete();
    pa.push_back(32'd10); pb.push_back(32'd2);
    pa.push_back(32'hFFFFFFFD); pb.push_back(32'd9);
    pa.push_back(32'd7); pb.push_back(32'hFFFFFFFC);
    pa.push_back(32'd100); pb.push_back(32'd1);
    run_cmd(4, 32'd0, 2'b00, 1'b0, 1'b1, 2, 3, 5, -1, 1'b1, 1'b1, {2'b00, 32'h00000041});

    pa.delete(); pb.delete();
    pa.push_back(32'h7FFFFFFF); pb.push_back(32'd2);
    pa.push_back(32'd1); pb.push_back(32'd1);
    run_cmd(2, 32'd0, 2'b00, 1'b1, 1'b0, -1, 0, 0, -1, 1'b0, 1'b1, {2'b01, 32'h7FFFFFFF});

    pa.delete(); pb.delete();
    for (int i = 0; i < 4; i++) begin pa.push_back(32'(i + 1)); pb.push_back(32'd5); end
    run_cmd(4, 32'd0, 2'b00, 1'b0, 1'b0, -1, 0, 1, 2, 1'b0, 1'b0, 34'd0);
    pa.delete(); pb.delete();
    pa.push_back(32'd3); pb.push_back(32'd3);
    run_cmd(1, 32'd0, 2'b00, 1'b0, 1'b0, -1, 0, 0, -1, 1'b0, 1'b1, {2'b00, 32'h00000009});

    @(posedge clk); #1;
    start = 1'b1; len = LW'(2); acc_init = 32'd0; mode_in = 2'b00;
    @(posedge clk); #1;
    start = 1'b0; op_a = 32'd7; op_b = 32'd7; op_valid = 1'b1;
    #2;
    chk("pre_reset_op_ready", 64'(op_ready), 64'd1);
    chk("pre_reset_mac_enable", 64'(mac_enable), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_op_ready", 64'(op_ready), 64'd0);
    chk("async_rst_mac_enable", 64'(mac_enable), 64'd0);
    op_valid = 1'b0;
    @(negedge clk);
    chk("async_rst_dot_result", 64'(dot_result), 64'd0);
    #2 rst_n = 1'b1;
    pa.delete(); pb.delete();
    pa.push_back(32'hFFFFFFFE); pb.push_back(32'd5);
    run_cmd(1, 32'd0, 2'b00, 1'b0, 1'b0, -1, 0, 0, -1, 1'b0, 1'b1, {2'b00, 32'hFFFFFFF6});

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(0, 6);
      pa.delete(); pb.delete();
      for (int i = 0; i < n; i++) begin pa.push_back(rand_op()); pb.push_back(rand_op()); end
      ga = $urandom_range(0, 6);
      gl = $urandom_range(0, 3);
      rr = $urandom_range(0, 3);
      ab = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n) : -1;
      sid = 1'($urandom_range(0, 1));
      run_cmd(n, rand_op(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ga, gl, rr, ab, sid, 1'b0, 34'd0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
